// File: rtl/apb_mem_slave.sv
// ============================================================================
// apb_mem_slave : APB slave with a DEPTH x 16-bit register memory and wait states
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module apb_mem_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [15:0] pw_data,
  output logic [15:0] pr_data,
  output logic        pready,
  output logic        pslverr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETUP_SEEN = 2'd1,
    ACCESS     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [15:0] wdata_q, wdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] mem_q [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;

  function automatic logic in_range(input logic [7:0] a);
    return ({1'b0, a} < 9'(DEPTH));
  endfunction

  // Out-of-range reads return zero rather than an aliased word.
  function automatic logic [15:0] read_word(input logic [7:0] a);
    return in_range(a) ? mem_q[a[AW-1:0]] : 16'h0000;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q[AW-1:0];
    mem_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = SETUP_SEEN;
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pw_data;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = !in_range(paddr);
            if (!pwrite) rdata_d = read_word(paddr);
          end
        end
      end
      SETUP_SEEN, ACCESS: begin
        if (!psel) begin
          state_d   = IDLE;
          cnt_d     = 4'd0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (penable) begin
          if (pready_q) begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            mem_we    = write_q && in_range(addr_q);
          end else begin
            // The SETUP_SEEN->ACCESS edge is the first counted access cycle.
            state_d = ACCESS;
            if (cnt_q != 4'd0) begin
              cnt_d = cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                pready_d  = 1'b1;
                pslverr_d = !in_range(addr_q);
                if (!write_q) rdata_d = read_word(addr_q);
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 8'h00;
      write_q   <= 1'b0;
      wdata_q   <= 16'h0000;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      rdata_q   <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      rdata_q   <= rdata_d;
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign pr_data = rdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
// ============================================================================
// tb_apb_mem_slave : scoreboard bench for apb_mem_slave (WAIT_STATES 2 and 0)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_apb_mem_slave;

  typedef struct packed {
    logic        err;
    logic        rd;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic        psel2 = 1'b0, psel0 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [15:0] pw_data = 16'h0000;
  logic [15:0] pr_data2, pr_data0;
  logic        pready2, pready0, pslverr2, pslverr0;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q2[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  apb_mem_slave #(.DEPTH(64), .WAIT_STATES(2)) u_ws2 (
    .pclk(clk), .preset(preset), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pw_data(pw_data), .pr_data(pr_data2), .pready(pready2), .pslverr(pslverr2)
  );

  apb_mem_slave #(.DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .pclk(clk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pw_data(pw_data), .pr_data(pr_data0), .pready(pready0), .pslverr(pslverr0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops one expectation per completed transfer.
  always @(negedge clk) begin
    exp_t e;
    if (psel2 && penable && pready2) begin
      if (q2.size() == 0) check("ws2_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        check("ws2_pslverr", {31'd0, pslverr2}, {31'd0, e.err});
        if (e.rd) check("ws2_rdata", {16'd0, pr_data2}, {16'd0, e.data});
      end
    end
    if (psel0 && penable && pready0) begin
      if (q0.size() == 0) check("ws0_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("ws0_pslverr", {31'd0, pslverr0}, {31'd0, e.err});
        if (e.rd) check("ws0_rdata", {16'd0, pr_data0}, {16'd0, e.data});
      end
    end
  end

  // Called just after a rising edge: setup cycle, then first access cycle.
  task automatic start(input bit ws0, input logic wr, input logic [7:0] a, input logic [15:0] d);
    if (ws0) psel0 = 1'b1; else psel2 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pw_data = d;
    @(posedge clk); #1;
    penable = 1'b1;
  endtask

  task automatic xfer(input bit ws0, input logic wr, input logic [7:0] a, input logic [15:0] d,
                      input logic err, input logic [15:0] exp_rd, input int exp_cyc, input bit glitch);
    int n;
    exp_t e;
    e.err = err; e.rd = !wr; e.data = exp_rd;
    if (ws0) q0.push_back(e); else q2.push_back(e);
    start(ws0, wr, a, d);
    n = 1;
    forever begin
      @(negedge clk);
      if (ws0 ? pready0 : pready2) break;
      if (n >= 20) begin
        check("ready_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
      n++;
      if (glitch && n == 2) begin
        pw_data = 16'h5555;
        paddr   = 8'h08;
      end
    end
    check(ws0 ? "ws0_access_cycles" : "ws2_access_cycles", n, exp_cyc);
    @(posedge clk); #1;
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    check("ready_cleared", {31'd0, ws0 ? pready0 : pready2}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    repeat (3) @(posedge clk);
    #1 preset = 1'b0;
    check("rst_pready2", {31'd0, pready2}, 32'd0);
    check("rst_pslverr2", {31'd0, pslverr2}, 32'd0);
    check("rst_prdata2", {16'd0, pr_data2}, 32'd0);
    check("rst_pready0", {31'd0, pready0}, 32'd0);

    // Three access cycles with two wait states, then read back.
    xfer(0, 1'b1, 8'h05, 16'hA4B8, 1'b0, 16'h0000, 3, 0);
    xfer(0, 1'b0, 8'h05, 16'h0000, 1'b0, 16'hA4B8, 3, 0);

    // Out-of-range write and read; pr_data holds across the write.
    xfer(0, 1'b1, 8'h49, 16'hFFFF, 1'b1, 16'h0000, 3, 0);
    check("prdata_hold", {16'd0, pr_data2}, {16'd0, 16'hA4B8});
    xfer(0, 1'b0, 8'h49, 16'h0000, 1'b1, 16'h0000, 3, 0);
    xfer(0, 1'b0, 8'h09, 16'h0000, 1'b0, 16'h0000, 3, 0);

    // Zero wait states, back-to-back write then read.
    xfer(1, 1'b1, 8'h10, 16'h1234, 1'b0, 16'h0000, 1, 0);
    xfer(1, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h1234, 1, 0);
    xfer(1, 1'b0, 8'h40, 16'h0000, 1'b1, 16'h0000, 1, 0);

    // psel dropped in the second access cycle aborts the write.
    xfer(0, 1'b1, 8'h02, 16'h1111, 1'b0, 16'h0000, 3, 0);
    start(0, 1'b1, 8'h02, 16'h2222);
    @(posedge clk); #1;
    psel2 = 1'b0; penable = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready2) saw = 1'b1;
    end
    check("abort_no_ready", {31'd0, saw}, 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 8'h02, 16'h0000, 1'b0, 16'h1111, 3, 0);

    // Data and address changes mid-access use the latched values.
    xfer(0, 1'b1, 8'h07, 16'hAAAA, 1'b0, 16'h0000, 3, 1);
    xfer(0, 1'b0, 8'h07, 16'h0000, 1'b0, 16'hAAAA, 3, 0);
    xfer(0, 1'b0, 8'h08, 16'h0000, 1'b0, 16'h0000, 3, 0);

    // Reset pulsed during ACCESS of a write to a word already holding data.
    xfer(0, 1'b1, 8'h03, 16'h1357, 1'b0, 16'h0000, 3, 0);
    xfer(0, 1'b0, 8'h03, 16'h0000, 1'b0, 16'h1357, 3, 0);
    start(0, 1'b1, 8'h03, 16'hBEEF);
    @(posedge clk); #1;
    preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    check("midrst_pready", {31'd0, pready2}, 32'd0);
    check("midrst_pslverr", {31'd0, pslverr2}, 32'd0);
    check("midrst_prdata", {16'd0, pr_data2}, 32'd0);
    check("midrst_prdata0", {16'd0, pr_data0}, 32'd0);
    psel2 = 1'b0; penable = 1'b0;
    xfer(0, 1'b0, 8'h03, 16'h0000, 1'b0, 16'h0000, 3, 0);
    xfer(0, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 3, 0);
    xfer(1, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h0000, 1, 0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", q2.size() + q0.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 Parameter DEPTH, default 64: number of 16-bit storage words; legal range 1..256.
REQ-002 Parameter WAIT_STATES, default 2: extra ACCESS cycles inserted before pready; legal range 0..15.
REQ-003 Port pclk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port preset, input, 1: synchronous, active-high reset, sampled on the pclk rising edge.
REQ-005 Port psel, input, 1: slave selected.
REQ-006 Port penable, input, 1: ACCESS phase indicator.
REQ-007 Port pwrite, input, 1: 1 = write, 0 = read.
REQ-008 Port paddr, input, 8: word address.
REQ-009 Port pw_data, input, 16: write data.
REQ-010 Port pr_data, output, 16: read data, registered.
REQ-011 Port pready, output, 1: transfer completion, registered.
REQ-012 Port pslverr, output, 1: error response, valid only while pready=1, registered.

Function
REQ-013 The block SHALL be a single clock domain, with all outputs driven directly from flops.
REQ-014 The FSM SHALL have three states: IDLE, SETUP_SEEN, and ACCESS.
REQ-015 In IDLE, sampling psel=1 and penable=0 SHALL move the FSM to SETUP_SEEN, latch paddr, pwrite, and pw_data, and load the wait counter with WAIT_STATES.
REQ-016 The same edge as REQ-015 SHALL set pready=1 when WAIT_STATES=0.
REQ-017 In SETUP_SEEN, sampling psel=1 and penable=1 SHALL move the FSM to ACCESS.
REQ-018 In ACCESS, each edge with the counter >0 SHALL decrement the counter, and the edge that takes the counter from 1 to 0 SHALL set pready=1.
REQ-019 The access SHALL last exactly WAIT_STATES+1 cycles with penable high, with pready high only in the last of those cycles.
REQ-020 A transfer SHALL complete on the edge sampling psel=1, penable=1, and pready=1. On that edge:
- pready and pslverr clear;
- the FSM returns to IDLE;
- a setup phase sampled on that same edge is not accepted; the next transfer starts from IDLE.
REQ-021 On a write completion with latched address < DEPTH, mem[addr] SHALL be updated with the latched pw_data on the completion edge.
REQ-022 On a read, pr_data SHALL be loaded with mem[latched addr] on the same edge that sets pready=1.
REQ-023 pr_data SHALL hold its value until the next read completion or reset.
REQ-024 If the latched address is >= DEPTH:
- pslverr SHALL be asserted together with pready;
- a write SHALL be discarded;
- a read SHALL load pr_data=16'h0000.
REQ-025 The block SHALL handle protocol violations as follows:
- psel deasserted in SETUP_SEEN or ACCESS: abort to IDLE, clear pready and pslverr, discard the write, leave memory and pr_data unchanged;
- penable=1 sampled in IDLE: ignored.
REQ-026 pw_data or paddr changes during ACCESS SHALL have no effect, because the values latched per REQ-015 are used.
REQ-027 A write followed by a read of the same address SHALL return the new data, with no read-after-write hazard.

Reset
REQ-028 preset=1 SHALL force, on the next edge:
- FSM to IDLE;
- pready=0, pslverr=0, pr_data=16'h0000;
- wait counter to 0;
- all DEPTH memory words to 16'h0000.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no memory write, and reset SHALL take priority over all other inputs.
REQ-030 After preset is deasserted, the first setup phase SHALL be accepted on the first following edge.

Verification
REQ-031 Scenario 1: WAIT_STATES=2, write addr 8'h05 data 16'hA4B8 -> pready high only in the 3rd penable cycle, pslverr=0, and a later read of 8'h05 returns 16'hA4B8.
REQ-032 Scenario 2: WAIT_STATES=0, back-to-back write 8'h10=16'h1234 then read 8'h10 -> pready high in the first access cycle of each transfer and pr_data=16'h1234.
REQ-033 Scenario 3: DEPTH=64, write 8'h49=16'hFFFF then read 8'h49 -> pslverr=1 with pready for both transfers, read data 16'h0000, and a read of 8'h09 stays 16'h0000 (no aliasing).
REQ-034 Scenario 4: psel dropped in the 2nd access cycle of a write to 8'h02 -> pready never asserts and a subsequent read of 8'h02 returns the prior value.
REQ-035 Scenario 5: preset pulsed during ACCESS of a write to 8'h03=16'hBEEF -> all outputs 0 on the next edge, and a read of 8'h03 returns 16'h0000.
REQ-036 Scenario 6: pw_data changed from 16'hAAAA to 16'h5555 mid-ACCESS of a write to 8'h07 -> a read of 8'h07 returns 16'hAAAA.
